// File: rtl/diffusion_pkg.sv
// Shared types and constants for the diffusion round controller.
// byte_idx gives the bit offset of byte[r][c] inside a 128-bit block.
package diffusion_pkg;

   typedef logic [127:0] state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   localparam int AES128_ROUNDS = 10;

   function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
      return 32'd8 * (32'd4 * r + c);
   endfunction

endpackage

// File: rtl/diffusion_round_fsm.sv
// Round sequencer: owns the FSM, round counter and block handshakes.
// All outputs are registered; load/step are decoded from those registers.
module diffusion_round_fsm
   import diffusion_pkg::*;
#(
   parameter int NUM_ROUNDS = AES128_ROUNDS,
   parameter int RW         = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          out_ready,
   output logic          in_ready,
   output logic          out_valid,
   output logic          busy,
   output logic [RW-1:0] round_idx,
   output logic          dp_final,
   output logic          load,
   output logic          step
);

   localparam logic [RW-1:0] LAST = RW'(NUM_ROUNDS);
   localparam logic [RW-1:0] ONE  = RW'(1);
   localparam logic [RW-1:0] ZERO = RW'(0);

   fsm_t          fsm_state;
   logic [RW-1:0] round_cnt;

   // load takes the block in IDLE; step marks a diffusion pass (ROUND only).
   assign load = in_ready & in_valid;
   assign step = busy & ~out_valid;

   // State transitions with outputs registered against the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_state <= IDLE;
         round_cnt <= ZERO;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         round_idx <= ZERO;
         dp_final  <= 1'b0;
      end else begin
         case (fsm_state)
            IDLE: begin
               if (in_valid) begin
                  fsm_state <= ROUND;
                  round_cnt <= ONE;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  round_idx <= ONE;
                  dp_final  <= (ONE == LAST);
               end else begin
                  fsm_state <= IDLE;
               end
            end
            ROUND: begin
               if (round_cnt == LAST) begin
                  fsm_state <= DONE;
                  out_valid <= 1'b1;
                  round_idx <= ZERO;
                  dp_final  <= 1'b0;
               end else begin
                  round_cnt <= round_cnt + ONE;
                  round_idx <= round_cnt + ONE;
                  dp_final  <= ((round_cnt + ONE) == LAST);
               end
            end
            DONE: begin
               // Output handshake only; a new block waits one cycle in IDLE.
               if (out_ready) begin
                  fsm_state <= IDLE;
                  round_cnt <= ZERO;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  fsm_state <= DONE;
               end
            end
            default: begin
               fsm_state <= IDLE;
               round_cnt <= ZERO;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               round_idx <= ZERO;
               dp_final  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/diffusion_round_ctrl.sv
// Iterative round controller: initial key add, then NUM_ROUNDS passes through
// the external combinational diffusion datapath, each followed by a key XOR.
module diffusion_round_ctrl
   import diffusion_pkg::*;
#(
   parameter int NUM_ROUNDS = AES128_ROUNDS,
   parameter int RW         = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  in_state,
   output logic [RW-1:0] round_idx,
   input  logic [127:0]  rk,
   output logic [127:0]  dp_in,
   output logic          dp_final,
   input  logic [127:0]  dp_out,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  out_state,
   output logic          busy
);

   state_t state_reg;
   logic   load;
   logic   step;

   diffusion_round_fsm #(
      .NUM_ROUNDS (NUM_ROUNDS),
      .RW         (RW)
   ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .busy      (busy),
      .round_idx (round_idx),
      .dp_final  (dp_final),
      .load      (load),
      .step      (step)
   );

   // Block state: key-add on accept, datapath plus key-add per round, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= 128'h0;
      end else if (load) begin
         state_reg <= in_state ^ rk;
      end else if (step) begin
         state_reg <= dp_out ^ rk;
      end else begin
         state_reg <= state_reg;
      end
   end

   assign dp_in     = state_reg;
   assign out_state = state_reg;

endmodule

// File: tb/tb_diffusion_round_ctrl.sv
// Bench for diffusion_round_ctrl: stub key schedule and datapath, reference
// model computing the expected block as key-add followed by N rounds.
module tb_diffusion_round_ctrl;
   import diffusion_pkg::*;

   localparam int N  = 10;
   localparam int N1 = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       in_valid = 1'b0, out_ready = 1'b0;
   state_t     in_state = 128'h0;
   logic       in_ready, out_valid, busy, dp_final;
   logic [3:0] round_idx;
   state_t     rk, dp_in, dp_out, out_state;

   logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
   state_t     in_state1 = 128'h0;
   logic       in_ready1, out_valid1, busy1, dp_final1;
   logic [3:0] round_idx1;
   state_t     rk1, dp_in1, dp_out1, out_state1;

   int          kmode = 0;
   int          dmode = 0;
   logic [31:0] kseed = 32'h0;
   int          tests = 0;
   int          failed = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Key stub: constant 1, round number, or a seeded pseudo-random key per round.
   function automatic state_t key_fn(input int mode, input logic [31:0] seed, input int r);
      logic [31:0] w;
      w = seed ^ (32'(r) * 32'h9E37_79B9);
      case (mode)
         0:       return 128'h1;
         1:       return {96'h0, 32'(r)};
         default: return {w, ~w, w ^ 32'h5A5A_5A5A, w[15:0], w[31:16]};
      endcase
   endfunction

   // Datapath stub: identity, or byte rotate plus a word-mix skipped in the final round.
   function automatic state_t dp_fn(input int mode, input state_t x, input logic fin);
      state_t y;
      if (mode == 0) return x;
      y = {x[119:0], x[127:120]};
      if (!fin) y = y ^ {y[95:0], y[127:96]};
      return y;
   endfunction

   function automatic state_t model(input state_t pt, input int n);
      state_t s;
      s = pt ^ key_fn(kmode, kseed, 0);
      for (int r = 1; r <= n; r++)
         s = dp_fn(dmode, s, r == n) ^ key_fn(kmode, kseed, r);
      return s;
   endfunction

   assign rk      = key_fn(kmode, kseed, int'(round_idx));
   assign dp_out  = dp_fn(dmode, dp_in, dp_final);
   assign rk1     = key_fn(kmode, kseed, int'(round_idx1));
   assign dp_out1 = dp_fn(dmode, dp_in1, dp_final1);

   diffusion_round_ctrl #(.NUM_ROUNDS(N), .RW(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_state(in_state), .round_idx(round_idx), .rk(rk), .dp_in(dp_in),
      .dp_final(dp_final), .dp_out(dp_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_state(out_state), .busy(busy)
   );

   diffusion_round_ctrl #(.NUM_ROUNDS(N1), .RW(4)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_state(in_state1), .round_idx(round_idx1), .rk(rk1), .dp_in(dp_in1),
      .dp_final(dp_final1), .dp_out(dp_out1), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_state(out_state1), .busy(busy1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input state_t obs, input state_t exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk1({tag, "_in_ready"}, in_ready, 1'b1);
      chk1({tag, "_out_valid"}, out_valid, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chki({tag, "_round_idx"}, int'(round_idx), 0);
      chk1({tag, "_dp_final"}, dp_final, 1'b0);
   endtask

   // One block through the N-round instance, checking every round cycle.
   task automatic run_block(input string tag, input state_t pt, output state_t obs);
      state_t exp;
      int     k;
      exp = model(pt, N);
      in_state = pt;
      in_valid = 1'b1;
      chk1({tag, "_ready"}, in_ready, 1'b1);
      chki({tag, "_idx0"}, int'(round_idx), 0);
      tick();
      in_valid = 1'b0;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      k = 1;
      while (!out_valid && k <= N + 5) begin
         chki({tag, "_idx"}, int'(round_idx), k);
         chk1({tag, "_final"}, dp_final, k == N);
         chk1({tag, "_busy"}, busy, 1'b1);
         k++;
         tick();
      end
      chk1({tag, "_out_valid"}, out_valid, 1'b1);
      chki({tag, "_rounds"}, k - 1, N);
      chk({tag, "_result"}, out_state, exp);
      obs = out_state;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_idle({tag, "_after"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      state_t      obs, pt, exp;
      state_t      exp_q[$];
      int          acc_t[$];
      int          nout, k, seen;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      chk_idle("reset");
      chk("reset_out_state", out_state, 128'h0);
      chk1("reset1_in_ready", in_ready1, 1'b1);
      chk1("reset1_out_valid", out_valid1, 1'b0);

      // Constant key 1, identity datapath: 11 XORs of 1
      kmode = 0; dmode = 0;
      run_block("const_key", 128'h0, obs);
      chk("const_key_value", obs, 128'h1);

      // Key = round number: XOR of 0..10
      kmode = 1; dmode = 0;
      run_block("idx_key", 128'h0, obs);
      chk("idx_key_value", obs, 128'hB);

      // Random keys, mixing datapath, random plaintexts
      kmode = 2; dmode = 1;
      for (int i = 0; i < 4; i++) begin
         kseed = $urandom;
         run_block("rand", {$urandom, $urandom, $urandom, $urandom}, obs);
      end

      // Back-pressure in DONE with in_valid asserted
      kseed = $urandom;
      pt = {$urandom, $urandom, $urandom, $urandom};
      exp = model(pt, N);
      in_state = pt;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < N + 5) begin
         k++;
         tick();
      end
      chk1("bp_out_valid", out_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_state = {$urandom, $urandom, $urandom, $urandom};
         tick();
         chk1("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_state", out_state, exp);
         chk1("bp_hold_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_idle("bp_release");
      tick();
      chk1("bp_idle_stays", in_ready, 1'b1);

      // Reset at round 4 aborts the block
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (int'(round_idx) != 4 && k < N + 5) begin
         k++;
         tick();
      end
      chki("rst_reach_idx4", int'(round_idx), 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle("rst_mid");
      chk("rst_mid_out_state", out_state, 128'h0);
      seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) seen++;
         tick();
      end
      out_ready = 1'b0;
      chki("rst_no_out_pulse", seen, 0);
      kseed = $urandom;
      run_block("rst_next", {$urandom, $urandom, $urandom, $urandom}, obs);

      // Back-to-back blocks, in_valid and out_ready held high
      out_ready = 1'b1;
      nout = 0;
      for (int i = 0; i < 52; i++) begin
         in_valid = (i < 40);
         in_state = {$urandom, $urandom, $urandom, $urandom};
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_state, N));
            acc_t.push_back(cyc);
         end
         if (out_valid) begin
            nout++;
            if (exp_q.size() > 0) chk("b2b_result", out_state, exp_q.pop_front());
            else chki("b2b_unexpected_out", nout, 0);
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chki("b2b_accepts", acc_t.size(), 4);
      chki("b2b_outputs", nout, 4);
      for (int j = 1; j < acc_t.size(); j++)
         chki("b2b_spacing", acc_t[j] - acc_t[j-1], N + 2);

      // Single-round instance: accept, one ROUND cycle, then DONE
      for (int i = 0; i < 2; i++) begin
         kseed = $urandom;
         pt = {$urandom, $urandom, $urandom, $urandom};
         in_state1 = pt;
         in_valid1 = 1'b1;
         chk1("n1_ready", in_ready1, 1'b1);
         tick();
         in_valid1 = 1'b0;
         chki("n1_idx", int'(round_idx1), 1);
         chk1("n1_final", dp_final1, 1'b1);
         chk1("n1_not_done", out_valid1, 1'b0);
         tick();
         chk1("n1_out_valid", out_valid1, 1'b1);
         chk("n1_result", out_state1, model(pt, N1));
         out_ready1 = 1'b1;
         tick();
         out_ready1 = 1'b0;
         chk1("n1_after_ready", in_ready1, 1'b1);
         chk1("n1_after_busy", busy1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
